// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_pkg : request codes, floor/state types, request decoders     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package elevator_pkg;

  typedef logic [1:0] floor_t;

  localparam logic [2:0] REQ_NONE = 3'b000;
  localparam logic [2:0] REQ_1U   = 3'b001;
  localparam logic [2:0] REQ_2U   = 3'b010;
  localparam logic [2:0] REQ_3U   = 3'b011;
  localparam logic [2:0] REQ_4D   = 3'b100;
  localparam logic [2:0] REQ_RSVD = 3'b101;
  localparam logic [2:0] REQ_2D   = 3'b110;
  localparam logic [2:0] REQ_3D   = 3'b111;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    LATCH      = 3'd2,
    MOVE       = 3'd3,
    DOOR_OPEN  = 3'd4,
    DOOR_CLOSE = 3'd5
  } state_t;

  function automatic logic req_is_none(input logic [2:0] code);
    return (code == REQ_NONE) || (code == REQ_RSVD);
  endfunction

  function automatic floor_t req_to_floor(input logic [2:0] code);
    floor_t f;
    case (code)
      REQ_1U:         f = 2'd0;
      REQ_2U, REQ_2D: f = 2'd1;
      REQ_3U, REQ_3D: f = 2'd2;
      REQ_4D:         f = 2'd3;
      default:        f = 2'd3;
    endcase
    return f;
  endfunction

  function automatic logic req_is_down(input logic [2:0] code);
    return code[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/elev_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elev_timer : loadable down-counter that saturates at zero             |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module elev_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_car_ctrl : single-car sequencer for a 4-floor elevator       |
// | Optional door re-open on obstruction: define DOOR_REOPEN_EN           |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int CLOSE_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       q_empty,
  input  logic [2:0] req_code,
  input  logic       obstruct,
  output logic       done,
  output logic [1:0] floor,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       door_closing,
  output logic       lantern_up,
  output logic       lantern_down,
  output logic       busy
);

  localparam int TMAX_A = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMAX   = (TMAX_A > CLOSE_CYCLES) ? TMAX_A : CLOSE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] c_TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] c_DOOR_LD   = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] c_CLOSE_LD  = TW'(CLOSE_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  floor_t        r_floor;
  floor_t        w_floor_nxt;
  floor_t        r_target;
  logic          r_dir_down;
  logic          w_latch;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_dec;
  logic          w_zero;
  floor_t        w_step_floor;
  logic          w_door_phase;

`ifndef DOOR_REOPEN_EN
  logic w_unused_obstruct;
  assign w_unused_obstruct = obstruct;
`endif

  elev_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign w_step_floor = (r_target > r_floor) ? (r_floor + 2'd1) : (r_floor - 2'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!q_empty) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_state_nxt = LATCH;
      end
      LATCH: begin
        if (req_is_none(req_code)) begin
          w_state_nxt = IDLE;
        end else begin
          w_latch = 1'b1;
          w_load  = 1'b1;
          if (req_to_floor(req_code) == r_floor) begin
            w_state_nxt = DOOR_OPEN;
            w_load_val  = c_DOOR_LD;
          end else begin
            w_state_nxt = MOVE;
            w_load_val  = c_TRAVEL_LD;
          end
        end
      end
      MOVE: begin
        if (w_zero) begin
          // One floor's worth of travel has elapsed: step and decide.
          w_floor_nxt = w_step_floor;
          w_load      = 1'b1;
          if (w_step_floor == r_target) begin
            w_state_nxt = DOOR_OPEN;
            w_load_val  = c_DOOR_LD;
          end else begin
            w_load_val  = c_TRAVEL_LD;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (w_zero) begin
          w_state_nxt = DOOR_CLOSE;
          w_load      = 1'b1;
          w_load_val  = c_CLOSE_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      DOOR_CLOSE: begin
`ifdef DOOR_REOPEN_EN
        if (obstruct) begin
          w_state_nxt = DOOR_OPEN;
          w_load      = 1'b1;
          w_load_val  = c_DOOR_LD;
        end else
`endif
        if (w_zero) begin
          w_state_nxt = IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_floor    <= '0;
      r_target   <= '0;
      r_dir_down <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_floor <= w_floor_nxt;
      if (w_latch) begin
        r_target   <= req_to_floor(req_code);
        r_dir_down <= req_is_down(req_code);
      end
    end
  end

  assign w_door_phase = (r_state == DOOR_OPEN) || (r_state == DOOR_CLOSE);

  assign done         = (r_state == FETCH);
  assign floor        = r_floor;
  assign motor_up     = (r_state == MOVE) && (r_target > r_floor);
  assign motor_down   = (r_state == MOVE) && (r_target < r_floor);
  assign door_open    = (r_state == DOOR_OPEN);
  assign door_closing = (r_state == DOOR_CLOSE);
  assign lantern_up   = w_door_phase && !r_dir_down;
  assign lantern_down = w_door_phase && r_dir_down;
  assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_elevator_car_ctrl : randomized bench against a per-request trace   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_elevator_car_ctrl;

  localparam int T = 4;
  localparam int D = 6;
  localparam int C = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       q_empty = 1'b1;
  logic [2:0] req_code = 3'b000;
  logic       obstruct = 1'b0;
  logic       done, motor_up, motor_down, door_open, door_closing;
  logic       lantern_up, lantern_down, busy;
  logic [1:0] floor;

  elevator_car_ctrl #(
    .TRAVEL_CYCLES (T),
    .DOOR_CYCLES   (D),
    .CLOSE_CYCLES  (C)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .q_empty      (q_empty),
    .req_code     (req_code),
    .obstruct     (obstruct),
    .done         (done),
    .floor        (floor),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .door_closing (door_closing),
    .lantern_up   (lantern_up),
    .lantern_down (lantern_down),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [9:0] exp_q[$];
  logic       obs_q[$];
  int         m_floor = 0;
  logic [9:0] w_obs;

  assign w_obs = {done, floor, motor_up, motor_down, door_open, door_closing,
                  lantern_up, lantern_down, busy};

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (done,floor,mu,md,open,close,lu,ld,busy) t=%0t",
                  tag, got, exp, $time);
  endtask

  function automatic logic [9:0] mkv(input bit dn, input int fl, input bit mu, input bit md,
                                     input bit dop, input bit dcl, input bit lu, input bit ld,
                                     input bit bz);
    logic [1:0] f2;
    f2 = fl[1:0];
    return {dn, f2, mu, md, dop, dcl, lu, ld, bz};
  endfunction

  // Obstruct noise; with re-open enabled it stays quiet unless a test wants it.
  function automatic logic pick_obs();
`ifdef DOOR_REOPEN_EN
    return 1'b0;
`else
    return 1'($urandom_range(0, 1));
`endif
  endfunction

  task automatic push(input logic [9:0] v, input logic o);
    exp_q.push_back(v);
    obs_q.push_back(o);
  endtask

  // Whole request as seen from outside: fetch, latch, floor-by-floor travel, door cycle.
  task automatic build_txn(input logic [2:0] code, input bit reopen);
    int f, t;
    bit dn;
    f = m_floor;
    push(mkv(1, f, 0, 0, 0, 0, 0, 0, 1), pick_obs());
    push(mkv(0, f, 0, 0, 0, 0, 0, 0, 1), pick_obs());
    if (code == 3'b000 || code == 3'b101) begin
      push(mkv(0, f, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      return;
    end
    t  = (code[1:0] == 2'b00) ? 3 : int'(code[1:0]) - 1;
    dn = code[2];
    while (f != t) begin
      for (int i = 0; i < T; i++) push(mkv(0, f, t > f, t < f, 0, 0, 0, 0, 1), pick_obs());
      f = (t > f) ? f + 1 : f - 1;
    end
    for (int i = 0; i < D; i++) push(mkv(0, t, 0, 0, 1, 0, !dn, dn, 1), pick_obs());
    if (reopen) begin
      push(mkv(0, t, 0, 0, 0, 1, !dn, dn, 1), 1'b1);
      for (int i = 0; i < D; i++) push(mkv(0, t, 0, 0, 1, 0, !dn, dn, 1), 1'b0);
    end
    for (int i = 0; i < C; i++) push(mkv(0, t, 0, 0, 0, 1, !dn, dn, 1), pick_obs());
    push(mkv(0, t, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    m_floor = t;
  endtask

  task automatic run_trace(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(posedge clk);
      #1;
      check(tag, w_obs, exp_q.pop_front());
      obstruct = obs_q.pop_front();
      q_empty  = 1'b1;
      n++;
    end
    exp_q.delete();
    obs_q.delete();
    obstruct = 1'b0;
  endtask

  task automatic request(input logic [2:0] code, input bit reopen, input string tag);
    q_empty  = 1'b0;
    req_code = code;
    build_txn(code, reopen);
    run_trace(tag, 1000);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle", w_obs, mkv(0, m_floor, 0, 0, 0, 0, 0, 0, 0));
      req_code = 3'($urandom_range(0, 7));
      obstruct = pick_obs();
    end
    obstruct = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", w_obs, 10'b0);
    rst_n   = 1'b1;
    m_floor = 0;
    idle_gap(20);

    request(3'b011, 1'b0, "up_0_to_2");
    idle_gap(2);
    request(3'b001, 1'b0, "down_2_to_0");
    idle_gap(1);
    request(3'b001, 1'b0, "same_floor");
    request(3'b100, 1'b0, "up_0_to_3");
    request(3'b000, 1'b0, "none_code");
    request(3'b101, 1'b0, "rsvd_code");
    request(3'b001, 1'b0, "down_3_to_0");

    // Abort while between floor 1 and the floor-3 target.
    q_empty  = 1'b0;
    req_code = 3'b100;
    build_txn(3'b100, 1'b0);
    run_trace("rst_move", 2 + T + 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid", w_obs, 10'b0);
    rst_n   = 1'b1;
    m_floor = 0;
    idle_gap(2);

`ifdef DOOR_REOPEN_EN
    request(3'b110, 1'b1, "reopen");
    idle_gap(1);
`endif

    for (int k = 0; k < 40; k++) begin
      request(3'($urandom_range(0, 7)), 1'b0, "rand_req");
      idle_gap(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
